// File: rtl/nvm_access_arbiter.sv
// Round-robin, burst-locked arbiter that shares one nv_memory port among N_REQ requesters.
// One beat per cycle; read data is returned RD_LATENCY cycles after each read beat.
module nvm_access_arbiter #(
  parameter int N_REQ          = 3,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int LEN_WIDTH      = 9,
  parameter int RD_LATENCY     = 1,
  parameter logic [MEM_ADDR_WIDTH-1:0] WP_BASE  = 8'h00,
  parameter logic [MEM_ADDR_WIDTH-1:0] WP_LIMIT = 8'h0F
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [N_REQ-1:0]                 i_req,
  input  logic [N_REQ-1:0]                 i_we,
  input  logic [N_REQ*MEM_ADDR_WIDTH-1:0]  i_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]       i_len,
  input  logic [N_REQ*MEM_DATA_WIDTH-1:0]  i_wdata,
  input  logic                             i_wp_en,
  output logic [N_REQ-1:0]                 o_gnt,
  output logic [N_REQ-1:0]                 o_beat_ack,
  output logic                             o_rvalid,
  output logic [MEM_DATA_WIDTH-1:0]        o_rdata,
  output logic [N_REQ-1:0]                 o_done,
  output logic                             o_wp_err,
  output logic                             o_mem_w,
  output logic [MEM_ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]        o_mem_data_in,
  input  logic [MEM_DATA_WIDTH-1:0]        i_mem_data_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_rr_ptr, r_idx;
  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]      r_len, r_beat;
  logic [2:0]                r_drain;
  logic                      r_wp_err;
  logic [RD_LATENCY-1:0]     r_rd_pipe;

  logic [MEM_ADDR_WIDTH-1:0] w_addr_arr  [N_REQ];
  logic [LEN_WIDTH-1:0]      w_len_arr   [N_REQ];
  logic [MEM_DATA_WIDTH-1:0] w_wdata_arr [N_REQ];

  logic                      w_found;
  logic [IDX_W-1:0]          w_sel, w_j, w_rr_nxt;
  logic [N_REQ-1:0]          w_idx_oh;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr, w_wp_off;
  logic                      w_in_wp, w_wp_hit, w_beat_last, w_drain_last;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_addr_arr[k]  = i_addr[k*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      w_len_arr[k]   = i_len[k*LEN_WIDTH +: LEN_WIDTH];
      w_wdata_arr[k] = i_wdata[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end
  end

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_sel   = w_j;
      end
    end
    w_rr_nxt = (w_sel == IDX_W'(N_REQ - 1)) ? '0 : w_sel + IDX_W'(1);
  end

  assign w_idx_oh     = N_REQ'(1) << r_idx;
  assign w_mem_addr   = r_addr + MEM_ADDR_WIDTH'(r_beat);
  // Offset form keeps the window test valid when WP_BASE is zero.
  assign w_wp_off     = w_mem_addr - WP_BASE;
  assign w_in_wp      = (w_wp_off <= (WP_LIMIT - WP_BASE));
  assign w_wp_hit     = r_we && i_wp_en && w_in_wp;
  assign w_beat_last  = (r_beat == r_len - LEN_WIDTH'(1));
  assign w_drain_last = (r_drain == 3'(RD_LATENCY - 1));

  assign o_rvalid = r_rd_pipe[RD_LATENCY-1];
  assign o_rdata  = o_rvalid ? i_mem_data_out : '0;

  always_comb begin
    w_state_nxt   = r_state;
    o_gnt         = '0;
    o_beat_ack    = '0;
    o_done        = '0;
    o_wp_err      = 1'b0;
    o_mem_w       = 1'b0;
    o_mem_addr    = '0;
    o_mem_data_in = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = (w_len_arr[w_sel] == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        o_gnt         = w_idx_oh;
        o_beat_ack    = w_idx_oh;
        o_mem_addr    = w_mem_addr;
        o_mem_data_in = w_wdata_arr[r_idx];
        o_mem_w       = r_we && !w_wp_hit;
        if (w_beat_last) begin
          w_state_nxt = r_we ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_gnt = w_idx_oh;
        if (w_drain_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_gnt       = w_idx_oh;
        o_done      = w_idx_oh;
        o_wp_err    = r_wp_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_drain   <= '0;
      r_wp_err  <= 1'b0;
      r_rd_pipe <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pipe[0] <= (r_state == S_XFER) && !r_we;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_rd_pipe[k] <= r_rd_pipe[k-1];
      end
      case (r_state)
        S_IDLE: begin
          r_beat   <= '0;
          r_drain  <= '0;
          r_wp_err <= 1'b0;
          if (w_found) begin
            r_idx    <= w_sel;
            r_we     <= i_we[w_sel];
            r_addr   <= w_addr_arr[w_sel];
            r_len    <= w_len_arr[w_sel];
            r_rr_ptr <= w_rr_nxt;
          end
        end
        S_XFER: begin
          r_beat <= w_beat_last ? '0 : r_beat + LEN_WIDTH'(1);
          if (w_wp_hit) begin
            r_wp_err <= 1'b1;
          end
        end
        S_DRAIN: r_drain <= r_drain + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_access_arbiter.sv
// Directed bench for nvm_access_arbiter: a latency-1 instance and a latency-3 instance,
// each attached to a behavioural nv_memory model.
module tb_nvm_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req, req3, we;
  logic [23:0] addr;
  logic [26:0] len;
  logic [95:0] wdata;
  logic        wp_en;

  logic [2:0]  gnt, ack, done;
  logic        rvalid, wp_err, mem_w;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [7:0]  mem_addr;

  logic [2:0]  gnt3, ack3, done3;
  logic        rvalid3, wp_err3, mem_w3;
  logic [31:0] rdata3, mem_din3, mem_dout3;
  logic [7:0]  mem_addr3;

  nvm_access_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .i_wp_en(wp_en), .o_gnt(gnt), .o_beat_ack(ack), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_done(done), .o_wp_err(wp_err), .o_mem_w(mem_w),
    .o_mem_addr(mem_addr), .o_mem_data_in(mem_din), .i_mem_data_out(mem_dout)
  );

  nvm_access_arbiter #(.RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_we(we), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .i_wp_en(wp_en), .o_gnt(gnt3), .o_beat_ack(ack3), .o_rvalid(rvalid3),
    .o_rdata(rdata3), .o_done(done3), .o_wp_err(wp_err3), .o_mem_w(mem_w3),
    .o_mem_addr(mem_addr3), .o_mem_data_in(mem_din3), .i_mem_data_out(mem_dout3)
  );

  // nv_memory models: synchronous read, extra output stages for the latency-3 instance.
  logic [31:0] mem [256];
  logic [31:0] mem3 [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem_q, m3_q1, m3_q2, m3_q3;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr]  <= bd_data;
      mem3[bd_addr] <= bd_data;
    end
    if (mem_w)  mem[mem_addr]   <= mem_din;
    if (mem_w3) mem3[mem_addr3] <= mem_din3;
    mem_q <= mem[mem_addr];
    m3_q1 <= mem3[mem_addr3];
    m3_q2 <= m3_q1;
    m3_q3 <= m3_q2;
  end
  assign mem_dout  = mem_q;
  assign mem_dout3 = m3_q3;

  // Requester write-data source: advances on the cycle after each beat_ack.
  logic [31:0] wvals [8];
  logic [2:0]  wptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wptr <= '0;
    else if (|done)  wptr <= '0;
    else if (|ack)   wptr <= wptr + 3'd1;
  end
  assign wdata = {3{wvals[wptr]}};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC000_0000 | 32'(a);
  endfunction

  task automatic setup(input int i, input logic w, input logic [7:0] a, input logic [8:0] l);
    we[i]          = w;
    addr[i*8 +: 8] = a;
    len[i*9 +: 9]  = l;
  endtask

  // Advance one cycle on the latency-1 instance and compare its outputs.
  task automatic cyc(input string tag, input logic [2:0] e_gnt, input logic [2:0] e_ack,
                     input logic [2:0] e_done, input logic e_w, input logic e_rv,
                     input logic [7:0] e_addr, input logic [31:0] e_rd, input logic e_wperr);
    tick();
    check_val({tag, ".gnt"},    32'(gnt),    32'(e_gnt));
    check_val({tag, ".ack"},    32'(ack),    32'(e_ack));
    check_val({tag, ".done"},   32'(done),   32'(e_done));
    check_val({tag, ".mem_w"},  32'(mem_w),  32'(e_w));
    check_val({tag, ".rvalid"}, 32'(rvalid), 32'(e_rv));
    if (e_ack != 3'b000) check_val({tag, ".addr"}, 32'(mem_addr), 32'(e_addr));
    if (e_rv)            check_val({tag, ".rdata"}, rdata, e_rd);
    if (e_done != 3'b000) check_val({tag, ".wp_err"}, 32'(wp_err), 32'(e_wperr));
  endtask

  logic [7:0] rr_a [3] = '{8'h20, 8'h30, 8'h50};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] oh;
    rst_n = 1'b0; req = '0; req3 = '0; we = '0; addr = '0; len = '0; wp_en = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 8; i++) wvals[i] = '0;

    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 8'(a);
      bd_data = (a >= 8'h40 && a <= 8'h43) ? 32'(8'hA0 + a - 8'h40) : pat(a);
    end
    @(negedge clk);
    bd_we = 1'b0;

    check_val("rst.gnt",    32'(gnt),    32'd0);
    check_val("rst.ack",    32'(ack),    32'd0);
    check_val("rst.done",   32'(done),   32'd0);
    check_val("rst.mem_w",  32'(mem_w),  32'd0);
    check_val("rst.rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin: all three hold req; order must be 0,1,2,0.
    setup(0, 1'b0, rr_a[0], 9'd1);
    setup(1, 1'b0, rr_a[1], 9'd1);
    setup(2, 1'b0, rr_a[2], 9'd1);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      oh = 3'(1 << (k % 3));
      cyc("rr.xfer",  oh, oh,     3'b000, 1'b0, 1'b0, rr_a[k % 3], 32'd0, 1'b0);
      cyc("rr.drain", oh, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0, pat(int'(rr_a[k % 3])), 1'b0);
      cyc("rr.done",  oh, 3'b000, oh,     1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
      if (k == 3) req = 3'b000;
      cyc("rr.idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    end

    // Read burst of 4 at 0x40 by requester 1.
    setup(1, 1'b0, 8'h40, 9'd4);
    req = 3'b010;
    cyc("rd.b0", 3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 8'h40, 32'd0, 1'b0);
    req = 3'b000;
    cyc("rd.b1",    3'b010, 3'b010, 3'b000, 1'b0, 1'b1, 8'h41, 32'hA0, 1'b0);
    cyc("rd.b2",    3'b010, 3'b010, 3'b000, 1'b0, 1'b1, 8'h42, 32'hA1, 1'b0);
    cyc("rd.b3",    3'b010, 3'b010, 3'b000, 1'b0, 1'b1, 8'h43, 32'hA2, 1'b0);
    cyc("rd.drain", 3'b010, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0,  32'hA3, 1'b0);
    cyc("rd.done",  3'b010, 3'b000, 3'b010, 1'b0, 1'b0, 8'd0,  32'd0,  1'b0);
    cyc("rd.idle",  3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0,  32'd0,  1'b0);

    // Write burst straddling the top of the protected window.
    wvals[0] = 32'h11; wvals[1] = 32'h22; wvals[2] = 32'h33;
    wp_en = 1'b1;
    setup(0, 1'b1, 8'h0E, 9'd3);
    req = 3'b001;
    cyc("wp.b0", 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 8'h0E, 32'd0, 1'b0);
    req = 3'b000;
    check_val("wp.din0", mem_din, 32'h11);
    cyc("wp.b1", 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 8'h0F, 32'd0, 1'b0);
    check_val("wp.din1", mem_din, 32'h22);
    cyc("wp.b2", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'h10, 32'd0, 1'b0);
    check_val("wp.din2", mem_din, 32'h33);
    cyc("wp.done", 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
    cyc("wp.idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    check_val("wp.mem10", mem[8'h10], 32'h33);
    check_val("wp.mem0E", mem[8'h0E], pat(8'h0E));
    check_val("wp.mem0F", mem[8'h0F], pat(8'h0F));
    wp_en = 1'b0;

    // Address wrap through 0xFF.
    setup(2, 1'b0, 8'hFE, 9'd4);
    req = 3'b100;
    cyc("wrap.b0", 3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 8'hFE, 32'd0, 1'b0);
    req = 3'b000;
    cyc("wrap.b1",    3'b100, 3'b100, 3'b000, 1'b0, 1'b1, 8'hFF, pat(8'hFE), 1'b0);
    cyc("wrap.b2",    3'b100, 3'b100, 3'b000, 1'b0, 1'b1, 8'h00, pat(8'hFF), 1'b0);
    cyc("wrap.b3",    3'b100, 3'b100, 3'b000, 1'b0, 1'b1, 8'h01, pat(8'h00), 1'b0);
    cyc("wrap.drain", 3'b100, 3'b000, 3'b000, 1'b0, 1'b1, 8'd0,  pat(8'h01), 1'b0);
    cyc("wrap.done",  3'b100, 3'b000, 3'b100, 1'b0, 1'b0, 8'd0,  32'd0, 1'b0);
    cyc("wrap.idle",  3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0,  32'd0, 1'b0);

    // Zero-length write: req launched at edge k, done visible after edge k+1.
    setup(0, 1'b1, 8'h10, 9'd0);
    req = 3'b001;
    cyc("z.done", 3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    req = 3'b000;
    cyc("z.idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);

    // Reset during beat 2 of an 8-beat write.
    for (int i = 0; i < 8; i++) wvals[i] = 32'h5000_0000 + 32'(i);
    setup(0, 1'b1, 8'h80, 9'd8);
    req = 3'b001;
    cyc("rw.b0", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'h80, 32'd0, 1'b0);
    req = 3'b000;
    cyc("rw.b1", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'h81, 32'd0, 1'b0);
    cyc("rw.b2", 3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 8'h82, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_val("rw.mem_w",  32'(mem_w),    32'd0);
    check_val("rw.gnt",    32'(gnt),      32'd0);
    check_val("rw.ack",    32'(ack),      32'd0);
    check_val("rw.done",   32'(done),     32'd0);
    check_val("rw.addr",   32'(mem_addr), 32'd0);
    check_val("rw.din",    mem_din,       32'd0);
    check_val("rw.rvalid", 32'(rvalid),   32'd0);
    check_val("rw.wp_err", 32'(wp_err),   32'd0);
    tick();
    check_val("rw.done_in_rst", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    check_val("rw.mem80", mem[8'h80], 32'h5000_0000);
    check_val("rw.mem81", mem[8'h81], 32'h5000_0001);
    check_val("rw.mem82", mem[8'h82], pat(8'h82));
    // After reset rr_ptr is 0, so requester 0 wins over 2, then 2 follows.
    setup(0, 1'b1, 8'h90, 9'd0);
    setup(2, 1'b1, 8'h91, 9'd0);
    req = 3'b101;
    cyc("rw.p0",   3'b001, 3'b000, 3'b001, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    cyc("rw.idle", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    cyc("rw.p2",   3'b100, 3'b000, 3'b100, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
    req = 3'b000;
    cyc("rw.end",  3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);

    // Latency-3 instance: len=2 read at 0x40 by requester 1.
    setup(1, 1'b0, 8'h40, 9'd2);
    req3 = 3'b010;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) req3 = 3'b000;
      check_val("l3.rvalid", 32'(rvalid3), 32'(i == 4 || i == 5));
      check_val("l3.done",   32'(done3),   (i == 6) ? 32'd2 : 32'd0);
      check_val("l3.gnt",    32'(gnt3),    (i <= 6) ? 32'd2 : 32'd0);
      if (i <= 2) check_val("l3.addr", 32'(mem_addr3), 32'(8'h40 + i - 1));
      if (i == 4) check_val("l3.rdata0", rdata3, 32'hA0);
      if (i == 5) check_val("l3.rdata1", rdata3, 32'hA1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
